// File: rtl/event_counter_pkg.sv
// event_counter_pkg: shared state type and saturating/wrapping increment helper.
package event_counter_pkg;
  typedef enum logic {IDLE, RESP} evtcnt_state_t;
  // Returns {overflow, next_count}; overflow fires when value is already at 2^width-1.
  function automatic logic [32:0] incSat(input logic [31:0] value, input int unsigned width, input bit saturate);
    logic [32:0] mx;
    mx = (33'd1 << width) - 33'd1;
    return ({1'b0, value} >= mx) ? {1'b1, saturate ? mx[31:0] : 32'd0} : {1'b0, value + 32'd1};
  endfunction
endpackage

// File: rtl/event_counter_chan.sv
// event_counter_chan: one event counter with sticky overflow flag and clear-to-INIT.
module event_counter_chan #(
  parameter int unsigned WIDTH = 16,
  parameter bit SATURATE = 1,
  parameter bit [31:0] INIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic cg_i,
  input  logic event_i,
  input  logic clear_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic ovf_o
);
  import event_counter_pkg::*;
  logic [WIDTH-1:0] cnt_q, cnt_d, base;
  logic ovf_q, ovf_d;
  logic [32:0] inc;
  // A clear rebases the counter to INIT and the same cycle's event still counts on top.
  always_comb begin
    base = clear_i ? INIT[WIDTH-1:0] : cnt_q;
    inc = incSat(32'(base), WIDTH, SATURATE);
    cnt_d = event_i ? WIDTH'(inc) : base;
    ovf_d = (ovf_q & ~clear_i) | (event_i & inc[32]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT[WIDTH-1:0];
      ovf_q <= 1'b0;
    end else if (cg_i) begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/event_counter_bank.sv
// event_counter_bank: N_CHAN event counters with a valid/ready snapshot-and-clear read port.
module event_counter_bank #(
  parameter int unsigned N_CHAN = 4,
  parameter int unsigned WIDTH = 16,
  parameter bit SATURATE = 1,
  parameter bit [31:0] INIT = 0,
  localparam int unsigned CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic [N_CHAN-1:0] i_event,
  input  logic i_rdReqValid,
  output logic o_rdReqReady,
  input  logic [CHAN_W-1:0] i_rdSel,
  input  logic i_rdClear,
  output logic o_rdRspValid,
  input  logic i_rdRspReady,
  output logic [WIDTH-1:0] o_rdData,
  output logic o_rdOvf,
  output logic o_rdErr
);
  import event_counter_pkg::*;
  if (N_CHAN == 0 || WIDTH == 0 || WIDTH > 32) begin : g_bad_params
    $fatal(1, "event_counter_bank: N_CHAN must be >=1 and WIDTH 1..32");
  end
  logic [WIDTH-1:0] cnt [N_CHAN];
  logic [N_CHAN-1:0] ovf, clr;
  logic [WIDTH-1:0] sel_data, data_q;
  logic sel_ovf, ovf_q, err_q, in_range, accept;
  evtcnt_state_t state_q;
  assign in_range = 32'(i_rdSel) < N_CHAN;
  assign accept = (state_q == IDLE) & i_rdReqValid & i_cg;
  // Out-of-range selects fall through to zero data and no ovf.
  always_comb begin
    sel_data = '0;
    sel_ovf = 1'b0;
    for (int k = 0; k < int'(N_CHAN); k++)
      if (32'(i_rdSel) == 32'(k)) begin
        sel_data = cnt[k];
        sel_ovf = ovf[k];
      end
  end
  for (genvar n = 0; n < N_CHAN; n++) begin : g_ch
    assign clr[n] = accept & i_rdClear & (32'(i_rdSel) == n);
    event_counter_chan #(.WIDTH(WIDTH), .SATURATE(SATURATE), .INIT(INIT)) u_chan (
      .clk(i_clk), .rst(i_rst), .cg_i(i_cg), .event_i(i_event[n]),
      .clear_i(clr[n]), .cnt_o(cnt[n]), .ovf_o(ovf[n])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (i_cg) begin
      if (state_q == IDLE && i_rdReqValid) begin
        state_q <= RESP;
        data_q <= sel_data;
        ovf_q <= sel_ovf;
        err_q <= ~in_range;
      end else if (state_q == RESP && i_rdRspReady) begin
        state_q <= IDLE;
      end
    end
  end
  assign o_rdReqReady = state_q == IDLE;
  assign o_rdRspValid = state_q == RESP;
  assign o_rdData = data_q;
  assign o_rdOvf = ovf_q;
  assign o_rdErr = err_q;
endmodule
